// File: rtl/tex_arb_pkg.sv
// Shared widths and the tag-entry type for the texture request arbiter.
// The defaults here describe the standard 4-requester, 8-deep configuration.
package tex_arb_pkg;

   localparam int unsigned NUM_REQS_DEF    = 4;
   localparam int unsigned MAX_PENDING_DEF = 8;
   localparam int unsigned IDX_W           = $clog2(NUM_REQS_DEF);
   localparam int unsigned CNT_W           = $clog2(MAX_PENDING_DEF + 1);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/tex_arb_tag_fifo.sv
// In-order tag FIFO that remembers which requester owns each outstanding request.
// It uses wrapping read/write pointers with an extra wrap bit to tell full from empty.
module tex_arb_tag_fifo
   import tex_arb_pkg::*;
#(
   parameter int unsigned DEPTH     = MAX_PENDING_DEF,
   parameter int unsigned CNT_WIDTH = CNT_W,
   parameter type         entry_t   = tag_t
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  entry_t               push_data,
   input  logic                 pop,
   output entry_t               head,
   output logic                 full,
   output logic                 empty,
   output logic [CNT_WIDTH-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] used;
   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];

   assign used  = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (used == PW'(DEPTH));
   assign count = CNT_WIDTH'(used);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + PW'(1);
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read between a push and its pop.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/tex_req_arbiter.sv
// Round-robin arbiter sharing one texture unit among NUM_REQS requesters.
// Responses return in order, so a local tag FIFO routes each one back to its owner.
module tex_req_arbiter
   import tex_arb_pkg::*;
#(
   parameter int unsigned NUM_REQS    = NUM_REQS_DEF,
   parameter int unsigned REQ_DATAW   = 128,
   parameter int unsigned RSP_DATAW   = 64,
   parameter int unsigned MAX_PENDING = MAX_PENDING_DEF
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQS-1:0]               req_valid,
   input  logic [NUM_REQS*REQ_DATAW-1:0]     req_data,
   output logic [NUM_REQS-1:0]               req_ready,
   output logic                              tex_req_valid,
   output logic [REQ_DATAW-1:0]              tex_req_data,
   input  logic                              tex_req_ready,
   input  logic                              tex_rsp_valid,
   input  logic [RSP_DATAW-1:0]              tex_rsp_data,
   output logic                              tex_rsp_ready,
   output logic [NUM_REQS-1:0]               rsp_valid,
   output logic [RSP_DATAW-1:0]              rsp_data,
   input  logic [NUM_REQS-1:0]               rsp_ready,
   output logic [$clog2(MAX_PENDING+1)-1:0]  pending,
   output logic                              idle,
   output logic                              err
);

   localparam int unsigned RI_W   = $clog2(NUM_REQS);
   localparam int unsigned SUM_W  = RI_W + 1;
   localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

   typedef logic [RI_W-1:0] req_tag_t;

   req_tag_t             ptr_q, ptr_d;
   req_tag_t             grant_idx, head_idx;
   logic [SUM_W-1:0]     cand, ptr_nxt;
   logic                 grant_found, accept, pop;
   logic                 fifo_full, fifo_empty;
   logic [PEND_W-1:0]    fifo_count;
   logic                 tex_req_valid_q, tex_req_valid_d;
   logic [REQ_DATAW-1:0] tex_req_data_q, tex_req_data_d;
   logic                 err_q, err_d;

   // First valid requester at or after ptr, wrapping around.
   always_comb begin
      grant_idx   = ptr_q;
      grant_found = 1'b0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
         cand = {1'b0, ptr_q} + SUM_W'(k);
         if (cand >= SUM_W'(NUM_REQS)) begin
            cand = cand - SUM_W'(NUM_REQS);
         end
         if (!grant_found && req_valid[cand[RI_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[RI_W-1:0];
         end
      end
   end

   assign accept = reset && grant_found && (!tex_req_valid_q || tex_req_ready) && !fifo_full;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_nxt = {1'b0, grant_idx} + SUM_W'(1);
      if (ptr_nxt >= SUM_W'(NUM_REQS)) begin
         ptr_nxt = '0;
      end
      ptr_d           = accept ? ptr_nxt[RI_W-1:0] : ptr_q;
      tex_req_valid_d = tex_req_valid_q;
      tex_req_data_d  = tex_req_data_q;
      if (accept) begin
         tex_req_valid_d = 1'b1;
         tex_req_data_d  = req_data[32'(grant_idx)*REQ_DATAW +: REQ_DATAW];
      end else if (tex_req_ready) begin
         tex_req_valid_d = 1'b0;
      end
      err_d = err_q | (tex_rsp_valid && fifo_empty);
   end

   // Response side is purely combinational: the FIFO head names the owner.
   always_comb begin
      rsp_valid = '0;
      if (reset && tex_rsp_valid && !fifo_empty) begin
         rsp_valid[head_idx] = 1'b1;
      end
   end

   assign tex_rsp_ready = reset && !fifo_empty && rsp_ready[head_idx];
   assign pop           = tex_rsp_valid && tex_rsp_ready;
   assign rsp_data      = tex_rsp_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q           <= '0;
         tex_req_valid_q <= 1'b0;
         tex_req_data_q  <= '0;
         err_q           <= 1'b0;
      end else begin
         ptr_q           <= ptr_d;
         tex_req_valid_q <= tex_req_valid_d;
         tex_req_data_q  <= tex_req_data_d;
         err_q           <= err_d;
      end
   end

   tex_arb_tag_fifo #(
      .DEPTH     (MAX_PENDING),
      .CNT_WIDTH (PEND_W),
      .entry_t   (req_tag_t)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (accept),
      .push_data (grant_idx),
      .pop       (pop),
      .head      (head_idx),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign tex_req_valid = tex_req_valid_q;
   assign tex_req_data  = tex_req_data_q;
   assign pending       = fifo_count;
   assign err           = err_q;
   assign idle          = !reset || ((fifo_count == '0) && !tex_req_valid_q);

endmodule

// File: tb/tb_tex_req_arbiter.sv
// Directed and randomized bench for tex_req_arbiter with a queue-based reference model.
module tb_tex_req_arbiter;

   localparam int N  = 4;
   localparam int RW = 128;
   localparam int SW = 64;
   localparam int MP = 8;
   localparam int PW = $clog2(MP + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*RW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            tex_req_valid;
   logic [RW-1:0]   tex_req_data;
   logic            tex_req_ready;
   logic            tex_rsp_valid;
   logic [SW-1:0]   tex_rsp_data;
   logic            tex_rsp_ready;
   logic [N-1:0]    rsp_valid;
   logic [SW-1:0]   rsp_data;
   logic [N-1:0]    rsp_ready;
   logic [PW-1:0]   pending;
   logic            idle;
   logic            err;

   always #5 clk = ~clk;

   tex_req_arbiter #(.NUM_REQS(N), .REQ_DATAW(RW), .RSP_DATAW(SW), .MAX_PENDING(MP)) dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tex_req_valid(tex_req_valid), .tex_req_data(tex_req_data), .tex_req_ready(tex_req_ready),
      .tex_rsp_valid(tex_rsp_valid), .tex_rsp_data(tex_rsp_data), .tex_rsp_ready(tex_rsp_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .pending(pending), .idle(idle), .err(err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: owner queue, rotating priority, output-register contents.
   int            m_ptr;
   int            m_q[$];
   bit            m_tv;
   logic [RW-1:0] m_td;
   bit            m_err;
   bit            m_acc;
   int            m_g;
   logic [N-1:0]  e_req_ready, e_rsp_valid;
   logic          e_trr, e_idle;

   task automatic model_comb();
      m_acc = 0; m_g = 0;
      e_req_ready = '0; e_rsp_valid = '0; e_trr = 1'b0; e_idle = 1'b1;
      if (rst_n) begin
         for (int k = 0; k < N; k++)
            if (!m_acc && req_valid[(m_ptr + k) % N]) begin m_acc = 1; m_g = (m_ptr + k) % N; end
         if (m_tv && !tex_req_ready) m_acc = 0;
         if (m_q.size() >= MP) m_acc = 0;
         if (m_acc) e_req_ready[m_g] = 1'b1;
         if (m_q.size() > 0) begin
            e_trr = rsp_ready[m_q[0]];
            if (tex_rsp_valid) e_rsp_valid[m_q[0]] = 1'b1;
         end
         e_idle = (m_q.size() == 0) && !m_tv;
      end
   endtask

   task automatic model_clock();
      if (!rst_n) begin
         m_ptr = 0; m_q.delete(); m_tv = 0; m_td = '0; m_err = 0;
      end else begin
         if (tex_rsp_valid && m_q.size() == 0) m_err = 1;
         if (tex_rsp_valid && e_trr) void'(m_q.pop_front());
         if (m_acc) begin
            m_q.push_back(m_g); m_tv = 1; m_td = req_data[m_g*RW +: RW]; m_ptr = (m_g + 1) % N;
         end else if (tex_req_ready) m_tv = 0;
      end
   endtask

   task automatic drive(input bit rn, input logic [N-1:0] rv, input bit trr,
                        input bit rsv, input logic [SW-1:0] rsd, input logic [N-1:0] rr);
      rst_n = rn; req_valid = rv; tex_req_ready = trr;
      tex_rsp_valid = rsv; tex_rsp_data = rsd; rsp_ready = rr;
      #1;
      model_comb();
   endtask

   task automatic tick();
      model_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_data();
      for (int w = 0; w < N*RW/32; w++) req_data[w*32 +: 32] = $urandom;
   endtask

   task automatic test_reset();
      fill_data();
      drive(0, 4'hF, 1, 1, 64'h55, 4'hF);
      n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); else n_pass++;
      n_checks++; if (tex_rsp_ready !== 1'b0) $display("FAIL reset_tex_rsp_ready got %b exp 0", tex_rsp_ready); else n_pass++;
      n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle); else n_pass++;
      tick();
      drive(0, 4'hF, 1, 1, 64'h55, 4'hF);
      tick();
      n_checks++; if (tex_req_valid !== 1'b0) $display("FAIL reset_tex_req_valid got %b exp 0", tex_req_valid); else n_pass++;
      n_checks++; if (tex_req_data !== '0) $display("FAIL reset_tex_req_data got %h exp 0", tex_req_data); else n_pass++;
      n_checks++; if (pending !== 4'd0) $display("FAIL reset_pending got %0d exp 0", pending); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
   endtask

   task automatic test_single();
      fill_data();
      req_data[2*RW +: RW] = 128'hA5;
      drive(1, 4'b0100, 1, 0, '0, 4'hF);
      n_checks++; if (req_ready !== 4'b0100) $display("FAIL single_req_ready got %b exp 0100", req_ready); else n_pass++;
      tick();
      n_checks++; if (tex_req_valid !== 1'b1) $display("FAIL single_tex_req_valid got %b exp 1", tex_req_valid); else n_pass++;
      n_checks++; if (tex_req_data !== 128'hA5) $display("FAIL single_tex_req_data got %h exp a5", tex_req_data); else n_pass++;
      n_checks++; if (pending !== 4'd1) $display("FAIL single_pending got %0d exp 1", pending); else n_pass++;
      drive(1, 4'b0, 1, 0, '0, 4'hF);
      tick();
      drive(1, 4'b0, 1, 1, 64'h11, 4'hF);
      n_checks++; if (rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid got %b exp 0100", rsp_valid); else n_pass++;
      n_checks++; if (rsp_data !== 64'h11) $display("FAIL single_rsp_data got %h exp 11", rsp_data); else n_pass++;
      n_checks++; if (tex_rsp_ready !== 1'b1) $display("FAIL single_tex_rsp_ready got %b exp 1", tex_rsp_ready); else n_pass++;
      tick();
      drive(1, 4'b0, 1, 0, '0, 4'hF);
      n_checks++; if (pending !== 4'd0) $display("FAIL single_pending_done got %0d exp 0", pending); else n_pass++;
      n_checks++; if (idle !== 1'b1) $display("FAIL single_idle got %b exp 1", idle); else n_pass++;
   endtask

   task automatic test_round_robin_full();
      logic [N-1:0] exp_g;
      fill_data();
      drive(0, 4'b0, 0, 0, '0, 4'hF); tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 4'hF, 1, 0, '0, 4'hF);
         exp_g = 4'(1 << (i % N));
         n_checks++; if (req_ready !== exp_g) $display("FAIL rr_grant_%0d got %b exp %b", i, req_ready, exp_g); else n_pass++;
         tick();
      end
      n_checks++; if (pending !== 4'd8) $display("FAIL rr_pending_full got %0d exp 8", pending); else n_pass++;
      drive(1, 4'hF, 1, 0, '0, 4'hF);
      n_checks++; if (req_ready !== 4'b0) $display("FAIL full_req_ready got %b exp 0000", req_ready); else n_pass++;
      tick();
      drive(1, 4'hF, 1, 1, 64'h77, 4'hF);
      n_checks++; if (tex_rsp_ready !== 1'b1) $display("FAIL full_pop_ready got %b exp 1", tex_rsp_ready); else n_pass++;
      n_checks++; if (req_ready !== 4'b0) $display("FAIL full_pop_no_push got %b exp 0000", req_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL full_pop_rsp_valid got %b exp 0001", rsp_valid); else n_pass++;
      tick();
      n_checks++; if (pending !== 4'd7) $display("FAIL full_pending_after_pop got %0d exp 7", pending); else n_pass++;
      drive(1, 4'hF, 1, 0, '0, 4'hF);
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL full_repush got %b exp 0001", req_ready); else n_pass++;
      tick();
      n_checks++; if (pending !== 4'd8) $display("FAIL full_pending_refill got %0d exp 8", pending); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         drive(1, 4'b0, 1, 1, 64'($urandom), 4'hF);
         n_checks++; if (rsp_valid !== e_rsp_valid) $display("FAIL drain_rsp_valid_%0d got %b exp %b", i, rsp_valid, e_rsp_valid); else n_pass++;
         tick();
      end
      n_checks++; if (pending !== 4'd0) $display("FAIL drain_pending got %0d exp 0", pending); else n_pass++;
   endtask

   task automatic test_stall();
      fill_data();
      req_data[0 +: RW]  = 128'hB0;
      req_data[RW +: RW] = 128'hB1;
      drive(0, 4'b0, 0, 0, '0, 4'hF); tick();
      drive(1, 4'b0001, 1, 0, '0, 4'hF);
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL stall_first_grant got %b exp 0001", req_ready); else n_pass++;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'b0010, 0, 0, '0, 4'hF);
         n_checks++; if (req_ready !== 4'b0) $display("FAIL stall_req_ready_%0d got %b exp 0000", i, req_ready); else n_pass++;
         tick();
         n_checks++; if (tex_req_valid !== 1'b1) $display("FAIL stall_valid_%0d got %b exp 1", i, tex_req_valid); else n_pass++;
         n_checks++; if (tex_req_data !== 128'hB0) $display("FAIL stall_data_%0d got %h exp b0", i, tex_req_data); else n_pass++;
      end
      drive(1, 4'b0010, 1, 0, '0, 4'hF);
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL stall_resume got %b exp 0010", req_ready); else n_pass++;
      tick();
      n_checks++; if (tex_req_data !== 128'hB1) $display("FAIL stall_next_data got %h exp b1", tex_req_data); else n_pass++;
      drive(1, 4'b0, 1, 0, '0, 4'hF); tick();
   endtask

   task automatic test_in_order();
      fill_data();
      drive(0, 4'b0, 0, 0, '0, 4'hF); tick();
      drive(1, 4'b0100, 1, 0, '0, 4'hF); tick();
      drive(1, 4'b0001, 1, 0, '0, 4'hF); tick();
      drive(1, 4'b1000, 1, 0, '0, 4'hF); tick();
      drive(1, 4'b0, 1, 0, '0, 4'hF); tick();
      n_checks++; if (pending !== 4'd3) $display("FAIL order_pending got %0d exp 3", pending); else n_pass++;
      drive(1, 4'b0, 1, 1, 64'h1, 4'hF);
      n_checks++; if (rsp_valid !== 4'b0100) $display("FAIL order_rsp0 got %b exp 0100", rsp_valid); else n_pass++;
      tick();
      drive(1, 4'b0, 1, 1, 64'h2, 4'b1110);
      n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL order_rsp1_held got %b exp 0001", rsp_valid); else n_pass++;
      n_checks++; if (tex_rsp_ready !== 1'b0) $display("FAIL order_backpressure got %b exp 0", tex_rsp_ready); else n_pass++;
      tick();
      n_checks++; if (pending !== 4'd2) $display("FAIL order_pending_held got %0d exp 2", pending); else n_pass++;
      drive(1, 4'b0, 1, 1, 64'h2, 4'hF);
      n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL order_rsp1 got %b exp 0001", rsp_valid); else n_pass++;
      n_checks++; if (rsp_data !== 64'h2) $display("FAIL order_rsp1_data got %h exp 2", rsp_data); else n_pass++;
      tick();
      drive(1, 4'b0, 1, 1, 64'h3, 4'hF);
      n_checks++; if (rsp_valid !== 4'b1000) $display("FAIL order_rsp2 got %b exp 1000", rsp_valid); else n_pass++;
      tick();
      n_checks++; if (pending !== 4'd0) $display("FAIL order_pending_done got %0d exp 0", pending); else n_pass++;
   endtask

   task automatic test_err_and_reset();
      drive(1, 4'b0, 1, 1, 64'hEE, 4'hF);
      n_checks++; if (tex_rsp_ready !== 1'b0) $display("FAIL err_tex_rsp_ready got %b exp 0", tex_rsp_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 4'b0) $display("FAIL err_rsp_valid got %b exp 0000", rsp_valid); else n_pass++;
      tick();
      n_checks++; if (err !== 1'b1) $display("FAIL err_set got %b exp 1", err); else n_pass++;
      drive(1, 4'b0011, 1, 0, '0, 4'hF); tick();
      n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err); else n_pass++;
      n_checks++; if (tex_req_valid !== 1'b1) $display("FAIL err_stream_valid got %b exp 1", tex_req_valid); else n_pass++;
      drive(0, 4'hF, 1, 1, 64'h9, 4'hF); tick();
      n_checks++; if (tex_req_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", tex_req_valid); else n_pass++;
      n_checks++; if (tex_req_data !== '0) $display("FAIL midrst_data got %h exp 0", tex_req_data); else n_pass++;
      n_checks++; if (pending !== 4'd0) $display("FAIL midrst_pending got %0d exp 0", pending); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL midrst_err got %b exp 0", err); else n_pass++;
   endtask

   task automatic test_random();
      drive(0, 4'b0, 0, 0, '0, 4'hF); tick();
      for (int c = 0; c < 600; c++) begin
         fill_data();
         drive($urandom_range(0, 59) != 0, 4'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) != 0, 64'({$urandom, $urandom}), 4'($urandom | $urandom));
         n_checks++; if (req_ready !== e_req_ready) $display("FAIL rnd_req_ready c%0d got %b exp %b", c, req_ready, e_req_ready); else n_pass++;
         n_checks++; if (rsp_valid !== e_rsp_valid) $display("FAIL rnd_rsp_valid c%0d got %b exp %b", c, rsp_valid, e_rsp_valid); else n_pass++;
         n_checks++; if (tex_rsp_ready !== e_trr) $display("FAIL rnd_tex_rsp_ready c%0d got %b exp %b", c, tex_rsp_ready, e_trr); else n_pass++;
         n_checks++; if (idle !== e_idle) $display("FAIL rnd_idle c%0d got %b exp %b", c, idle, e_idle); else n_pass++;
         tick();
         n_checks++; if (tex_req_valid !== m_tv) $display("FAIL rnd_tex_req_valid c%0d got %b exp %b", c, tex_req_valid, m_tv); else n_pass++;
         n_checks++; if (tex_req_data !== m_td) $display("FAIL rnd_tex_req_data c%0d got %h exp %h", c, tex_req_data, m_td); else n_pass++;
         n_checks++; if (pending !== PW'(m_q.size())) $display("FAIL rnd_pending c%0d got %0d exp %0d", c, pending, m_q.size()); else n_pass++;
         n_checks++; if (err !== m_err) $display("FAIL rnd_err c%0d got %b exp %b", c, err, m_err); else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_data = '0; tex_req_ready = 1'b0;
      tex_rsp_valid = 1'b0; tex_rsp_data = '0; rsp_ready = '0;
      m_ptr = 0; m_tv = 0; m_td = '0; m_err = 0;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_round_robin_full();
      test_stall();
      test_in_order();
      test_err_and_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
